// File: rtl/keccak_pkg.sv
// Shared Keccak-f definitions for the round pipeline stages (theta/rho/pi/chi/iota).
package keccak_pkg;

  localparam int DEF_LANE_W  = 64;
  localparam int DEF_ROUND_W = 5;
  localparam int NROUNDS     = 24;

  // State is indexed [x][y][z]
  typedef logic [4:0][4:0][DEF_LANE_W-1:0] state_t;
  typedef logic [DEF_ROUND_W-1:0]          round_t;

  function automatic int xwrap(input int x);
    return x % 5;
  endfunction

endpackage

// File: rtl/stagechi_if.sv
// Handshake bundle around the chi stage: upstream beat in, chi result out.
interface stagechi_if #(
  parameter int LANE_W  = keccak_pkg::DEF_LANE_W,
  parameter int ROUND_W = keccak_pkg::DEF_ROUND_W
);

  logic                          in_valid;
  logic                          in_ready;
  logic [ROUND_W-1:0]            iround_in;
  logic [4:0][4:0][LANE_W-1:0]   din;
  logic                          out_valid;
  logic                          out_ready;
  logic [ROUND_W-1:0]            iround_out;
  logic [4:0][4:0][LANE_W-1:0]   dout;

  // master: the environment around the stage (producer upstream, consumer downstream)
  modport master (
    output in_valid, iround_in, din, out_ready,
    input  in_ready, out_valid, iround_out, dout
  );

  modport slave (
    input  in_valid, iround_in, din, out_ready,
    output in_ready, out_valid, iround_out, dout
  );

endinterface

// File: rtl/chi_row.sv
// Combinational chi over one plane row y: five lanes, x neighbours wrap mod 5.
module chi_row
  import keccak_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [4:0][LANE_W-1:0] row_in,
  output logic [4:0][LANE_W-1:0] row_out
);

  for (genvar x = 0; x < 5; x++) begin : g_lane
    assign row_out[x] = row_in[x] ^ (~row_in[xwrap(x + 1)] & row_in[xwrap(x + 2)]);
  end

endmodule

// File: rtl/stagechi.sv
// Keccak-f chi step with a 2-entry skid buffer on the output; round index rides along.
module stagechi
  import keccak_pkg::*;
#(
  parameter int LANE_W  = DEF_LANE_W,
  parameter int ROUND_W = DEF_ROUND_W
) (
  input  logic       clk,
  input  logic       rst,
  stagechi_if.slave  bus
);

  // occupancy | meaning
  // 0         | empty: in_ready=1, out_valid=0
  // 1         | main holds a result: in_ready=1, out_valid=1
  // 2         | main and skid full: in_ready=0, out_valid=1

  logic [4:0][4:0][LANE_W-1:0] row_in;   // [y][x]
  logic [4:0][4:0][LANE_W-1:0] row_out;  // [y][x]
  logic [4:0][4:0][LANE_W-1:0] chi;      // [x][y]

  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_col
      assign row_in[y][x] = bus.din[x][y];
      assign chi[x][y]    = row_out[y][x];
    end
    chi_row #(.LANE_W(LANE_W)) u_chi_row (
      .row_in  (row_in[y]),
      .row_out (row_out[y])
    );
  end

  logic [1:0]                  cnt_q, cnt_d;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [4:0][4:0][LANE_W-1:0] main_q, skid_q;
  logic [ROUND_W-1:0]          main_rnd_q, skid_rnd_q;
  logic                        acc, con;

  assign acc = bus.in_valid & in_ready_q;
  assign con = out_valid_q & bus.out_ready;

  always_comb begin
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: if (acc) cnt_d = 2'd1;
      2'd1: begin
        if (acc && !con)      cnt_d = 2'd2;
        else if (!acc && con) cnt_d = 2'd0;
      end
      2'd2: if (con) cnt_d = 2'd1;
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      main_rnd_q  <= '0;
      skid_q      <= '0;
      skid_rnd_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      in_ready_q  <= (cnt_d != 2'd2);
      out_valid_q <= (cnt_d != 2'd0);
      // acc is impossible at occupancy 2 because in_ready is low there
      if (cnt_q == 2'd2 && con) begin
        main_q     <= skid_q;
        main_rnd_q <= skid_rnd_q;
      end else if (acc && (cnt_q == 2'd0 || con)) begin
        main_q     <= chi;
        main_rnd_q <= bus.iround_in;
      end
      if (acc && cnt_q == 2'd1 && !con) begin
        skid_q     <= chi;
        skid_rnd_q <= bus.iround_in;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.dout       = main_q;
  assign bus.iround_out = main_rnd_q;

endmodule
